csr_regfile: RTL and testbench
==============================

CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 The block SHALL have parameter MTVEC_RST, default 32'h0000_0000, giving the reset value of mtvec.
REQ-002 The block SHALL have parameter MISA_VAL, default 32'h4000_0100 (RV32I), giving the read-only misa value.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port rd_addr, input, 12 bits, the CSR read address from decode.
REQ-006 The block SHALL have port rd_data, output, `rv32_XLEN bits, the CSR read value, which feeds Op2 of the CSR execute unit.
REQ-007 The block SHALL have port rd_illegal, output, 1 bit, asserted when rd_addr is unimplemented.
REQ-008 The block SHALL have port wr_en, input, 1 bit, the CSR write strobe from writeback.
REQ-009 The block SHALL have port wr_addr, input, 12 bits, the CSR write address.
REQ-010 The block SHALL have port wr_data, input, `rv32_XLEN bits, the CSR_res from the execute unit.
REQ-011 The block SHALL have port retire, input, 1 bit, a one-cycle pulse per retired instruction.
REQ-012 The block SHALL have the trap ports trap_valid (1 bit), trap_pc (32 bits) and trap_cause (32 bits), all inputs, carrying the trap entry request.
REQ-013 The block SHALL have port mret, input, 1 bit, signalling a trap return.
REQ-014 The block SHALL have the outputs mtvec_o (32 bits), mepc_o (32 bits) and mie_o (1 bit, mstatus.MIE).

Function
REQ-015 The block SHALL implement mstatus (0x300), misa (0x301), mtvec (0x305), mscratch (0x340), mepc (0x341), mcause (0x342), mcycle/mcycleh (0xB00/0xB80), minstret/minstreth (0xB02/0xB82) and mhartid (0xF14, reads 0).
REQ-016 rd_data SHALL be combinational from current register state; any other address SHALL give rd_data = 0 and rd_illegal = 1.
REQ-017 A write SHALL take effect at the next edge, so a same-cycle read returns the old value and forwarding belongs to the pipeline.
REQ-018 Writes to misa, mhartid and unimplemented addresses SHALL be ignored.
REQ-019 mstatus SHALL store only MIE (bit 3) and MPIE (bit 7); MPP (bits 12:11) SHALL read 2'b11 and all other bits SHALL read 0.
REQ-020 mepc bits 1:0 and mtvec bits 1:0 SHALL always read 0.
REQ-021 mcycle SHALL increment by 1 every cycle as a 64-bit counter, wrapping from all-ones to 0.
REQ-022 minstret SHALL increment on retire as a 64-bit counter with the same wrap behaviour.
REQ-023 A software write to either 32-bit half of a counter SHALL replace that half and suppress the increment that cycle; the other half SHALL hold.
REQ-024 On trap_valid the block SHALL set mepc <= trap_pc, mcause <= trap_cause, MPIE <= MIE and MIE <= 0.
REQ-025 On mret the block SHALL set MIE <= MPIE and MPIE <= 1.
REQ-026 Priority SHALL be trap_valid > mret > wr_en for mstatus, mepc and mcause, with the losing update discarded.
REQ-027 Counter increments SHALL continue unaffected by traps.

Reset
REQ-028 On rst_n low, all registers SHALL clear immediately, except mtvec, which SHALL load MTVEC_RST.
REQ-029 Outputs after reset SHALL be: mie_o = 0, mepc_o = 0, mtvec_o = MTVEC_RST, rd_illegal per rd_addr.
REQ-030 Deassertion of reset SHALL be synchronized externally, and counters SHALL start counting on the first edge after deassertion.

Structure
REQ-031 CSR address constants and mstatus bit indices SHALL be added to risc_v_defines.v.
REQ-032 One sub-module, csr_counter64, SHALL be used (instantiated twice) for the 64-bit counter with half-word write and increment enable.

Verification
REQ-033 Bench SHALL cover: reset, then read 0x305 -> MTVEC_RST; read 0x7C0 -> rd_data = 0, rd_illegal = 1.
REQ-034 Bench SHALL cover: write 0x340 = 32'hDEAD_BEEF; the same-cycle read returns 0 and the next-cycle read returns 32'hDEAD_BEEF.
REQ-035 Bench SHALL cover: mcycle written to 32'hFFFF_FFFF with mcycleh = 0, then one cycle -> mcycle = 0, mcycleh = 1.
REQ-036 Bench SHALL cover: MIE = 1, trap_valid with pc 32'h0000_1234 and cause 11 -> mepc = 32'h0000_1234, mcause = 11, MIE = 0, MPIE = 1; then mret -> MIE = 1.
REQ-037 Bench SHALL cover: trap_valid and wr_en to mepc (value 32'h40) in the same cycle -> mepc = trap_pc.
REQ-038 Bench SHALL cover: rst_n asserted mid-count -> counters read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/csr_regfile_pkg.sv
// csr_regfile_pkg: CSR addresses, mstatus bit positions and read-value helper
package csr_regfile_pkg;
  localparam int XLEN = 32;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  // MPP is hardwired to machine mode
  function automatic logic [XLEN-1:0] mstatus_val(input logic mie, input logic mpie);
    mstatus_val = 32'h0000_1800;
    mstatus_val[MSTATUS_MIE] = mie;
    mstatus_val[MSTATUS_MPIE] = mpie;
  endfunction
endpackage

// File: rtl/csr_regfile_counter64.sv
// csr_counter64: 64-bit counter with per-half software write that overrides increment
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] value
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (wr_lo || wr_hi) value <= {wr_hi ? wr_data : value[63:32], wr_lo ? wr_data : value[31:0]};
    else if (inc) value <= value + 64'd1;
endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR file with trap entry/return and 64-bit cycle/instret counters
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_illegal,
  input  logic            wr_en,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            retire,
  input  logic            trap_valid,
  input  logic [31:0]     trap_pc,
  input  logic [31:0]     trap_cause,
  input  logic            mret,
  output logic [31:0]     mtvec_o,
  output logic [31:0]     mepc_o,
  output logic            mie_o
);
  logic        mie, mpie;
  logic [31:0] mtvec, mscratch, mepc, mcause;
  logic [63:0] mcycle, minstret;
  logic        wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
  assign wr_mstatus  = wr_en && wr_addr == CSR_MSTATUS;
  assign wr_mtvec    = wr_en && wr_addr == CSR_MTVEC;
  assign wr_mscratch = wr_en && wr_addr == CSR_MSCRATCH;
  assign wr_mepc     = wr_en && wr_addr == CSR_MEPC;
  assign wr_mcause   = wr_en && wr_addr == CSR_MCAUSE;
  csr_counter64 u_cycle (
    .clk(clk), .rst_n(rst_n), .inc(1'b1),
    .wr_lo(wr_en && wr_addr == CSR_MCYCLE), .wr_hi(wr_en && wr_addr == CSR_MCYCLEH),
    .wr_data(wr_data), .value(mcycle)
  );
  csr_counter64 u_instret (
    .clk(clk), .rst_n(rst_n), .inc(retire),
    .wr_lo(wr_en && wr_addr == CSR_MINSTRET), .wr_hi(wr_en && wr_addr == CSR_MINSTRETH),
    .wr_data(wr_data), .value(minstret)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mie <= 1'b0;
      mpie <= 1'b0;
      mtvec <= MTVEC_RST & ~32'h3;
      mscratch <= '0;
      mepc <= '0;
      mcause <= '0;
    end else begin
      if (wr_mtvec) mtvec <= wr_data & ~32'h3;
      if (wr_mscratch) mscratch <= wr_data;
      if (trap_valid) begin
        mie <= 1'b0;
        mpie <= mie;
        mepc <= trap_pc & ~32'h3;
        mcause <= trap_cause;
      end else begin
        if (mret) begin
          mie <= mpie;
          mpie <= 1'b1;
        end else if (wr_mstatus) begin
          mie <= wr_data[MSTATUS_MIE];
          mpie <= wr_data[MSTATUS_MPIE];
        end
        if (wr_mepc) mepc <= wr_data & ~32'h3;
        if (wr_mcause) mcause <= wr_data;
      end
    end
  always_comb begin
    rd_data = '0;
    rd_illegal = 1'b0;
    case (rd_addr)
      CSR_MSTATUS:   rd_data = mstatus_val(mie, mpie);
      CSR_MISA:      rd_data = MISA_VAL;
      CSR_MTVEC:     rd_data = mtvec;
      CSR_MSCRATCH:  rd_data = mscratch;
      CSR_MEPC:      rd_data = mepc;
      CSR_MCAUSE:    rd_data = mcause;
      CSR_MCYCLE:    rd_data = mcycle[31:0];
      CSR_MCYCLEH:   rd_data = mcycle[63:32];
      CSR_MINSTRET:  rd_data = minstret[31:0];
      CSR_MINSTRETH: rd_data = minstret[63:32];
      CSR_MHARTID:   rd_data = '0;
      default:       rd_illegal = 1'b1;
    endcase
  end
  assign mtvec_o = mtvec;
  assign mepc_o  = mepc;
  assign mie_o   = mie;
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: reference-model plus directed checks for csr_regfile
module tb_csr_regfile;
  localparam logic [31:0] MTVEC_RST = 32'h8000_0100;
  localparam logic [31:0] MISA_VAL  = 32'h4000_0100;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [11:0] rd_addr = '0, wr_addr = '0;
  logic [31:0] rd_data, wr_data = '0, trap_pc = '0, trap_cause = '0, mtvec_o, mepc_o;
  logic rd_illegal, wr_en = 1'b0, retire = 1'b0, trap_valid = 1'b0, mret = 1'b0, mie_o;
  int checks = 0, errors = 0;
  csr_regfile #(.MTVEC_RST(MTVEC_RST), .MISA_VAL(MISA_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_illegal(rd_illegal),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .retire(retire),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause), .mret(mret),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
  );
  always #5 clk = ~clk;
  // Architectural model: visible register values plus plain 64-bit counters
  bit m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  longint unsigned m_cyc, m_ins;
  function automatic void model_read(input logic [11:0] a, output logic [31:0] d, output logic ill);
    ill = 1'b0;
    case (a)
      12'h300: d = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h301: d = MISA_VAL;
      12'h305: d = m_mtvec;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'hB00: d = m_cyc[31:0];
      12'hB80: d = m_cyc[63:32];
      12'hB02: d = m_ins[31:0];
      12'hB82: d = m_ins[63:32];
      12'hF14: d = 32'h0;
      default: begin d = 32'h0; ill = 1'b1; end
    endcase
  endfunction
  always @(posedge clk or negedge rst_n) begin
    bit n_mie, n_mpie;
    longint unsigned n_cyc, n_ins;
    if (!rst_n) begin
      m_mie = 0; m_mpie = 0; m_mtvec = MTVEC_RST & 32'hFFFF_FFFC;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
    end else begin
      n_mie = m_mie; n_mpie = m_mpie;
      n_cyc = m_cyc + 1; n_ins = m_ins + (retire ? 1 : 0);
      if (wr_en) begin
        if (wr_addr == 12'h305) m_mtvec = {wr_data[31:2], 2'b00};
        if (wr_addr == 12'h340) m_mscratch = wr_data;
        if (wr_addr == 12'hB00) n_cyc = {m_cyc[63:32], wr_data};
        if (wr_addr == 12'hB80) n_cyc = {wr_data, m_cyc[31:0]};
        if (wr_addr == 12'hB02) n_ins = {m_ins[63:32], wr_data};
        if (wr_addr == 12'hB82) n_ins = {wr_data, m_ins[31:0]};
      end
      if (trap_valid) begin
        n_mpie = m_mie; n_mie = 0; m_mepc = {trap_pc[31:2], 2'b00}; m_mcause = trap_cause;
      end else begin
        if (mret) begin n_mie = m_mpie; n_mpie = 1; end
        else if (wr_en && wr_addr == 12'h300) begin n_mie = wr_data[3]; n_mpie = wr_data[7]; end
        if (wr_en && wr_addr == 12'h341) m_mepc = {wr_data[31:2], 2'b00};
        if (wr_en && wr_addr == 12'h342) m_mcause = wr_data;
      end
      m_mie = n_mie; m_mpie = n_mpie; m_cyc = n_cyc; m_ins = n_ins;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [31:0] d;
    logic ill;
    model_read(rd_addr, d, ill);
    chk($sformatf("model rd_data @%03h", rd_addr), rd_data, d);
    chk("model rd_illegal", 32'(rd_illegal), 32'(ill));
    chk("model mtvec_o", mtvec_o, m_mtvec);
    chk("model mepc_o", mepc_o, m_mepc);
    chk("model mie_o", 32'(mie_o), 32'(m_mie));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask
  initial begin
    #12;
    rd("reset mtvec", 12'h305, 32'h8000_0100);
    chk("reset mtvec_o", mtvec_o, 32'h8000_0100);
    chk("reset mie_o", 32'(mie_o), 32'h0);
    chk("reset mepc_o", mepc_o, 32'h0);
    rd("reset mstatus", 12'h300, 32'h0000_1800);
    rd("misa", 12'h301, 32'h4000_0100);
    rd("mhartid", 12'hF14, 32'h0);
    chk("mhartid legal", 32'(rd_illegal), 32'h0);
    rd("unimpl data", 12'h7C0, 32'h0);
    chk("unimpl illegal", 32'(rd_illegal), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd_addr = 12'h340; wr_en = 1'b1; wr_addr = 12'h340; wr_data = 32'hDEAD_BEEF;
    #1;
    chk("mscratch same-cycle", rd_data, 32'h0);
    tick();
    wr_en = 1'b0;
    rd("mscratch next-cycle", 12'h340, 32'hDEAD_BEEF);
    wr(12'h301, 32'h1234_5678);
    wr(12'h7C0, 32'h1234_5678);
    rd("misa after write", 12'h301, 32'h4000_0100);
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    rd("mcycle held by hi write", 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd("mcycle wrapped", 12'hB00, 32'h0);
    rd("mcycleh carry", 12'hB80, 32'h1);
    wr(12'h300, 32'hFFFF_FFFF);
    rd("mstatus masked", 12'h300, 32'h0000_1888);
    wr(12'h300, 32'h0000_0008);
    chk("mie set", 32'(mie_o), 32'h1);
    trap_valid = 1'b1; trap_pc = 32'h0000_1234; trap_cause = 32'd11;
    tick();
    trap_valid = 1'b0;
    chk("trap mepc_o", mepc_o, 32'h0000_1234);
    rd("trap mcause", 12'h342, 32'd11);
    rd("trap mstatus", 12'h300, 32'h0000_1880);
    chk("trap mie_o", 32'(mie_o), 32'h0);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("mret mie_o", 32'(mie_o), 32'h1);
    rd("mret mstatus", 12'h300, 32'h0000_1888);
    trap_valid = 1'b1; trap_pc = 32'h0000_2000; trap_cause = 32'd2;
    wr(12'h341, 32'h0000_0040);
    trap_valid = 1'b0;
    chk("trap beats wr mepc", mepc_o, 32'h0000_2000);
    wr(12'h341, 32'h0000_0103);
    rd("mepc low bits", 12'h341, 32'h0000_0100);
    wr(12'h305, 32'h0000_0207);
    chk("mtvec low bits", mtvec_o, 32'h0000_0204);
    for (int i = 0; i < 3; i++) begin
      retire = 1'b1;
      tick();
      retire = 1'b0;
      tick();
    end
    rd("minstret", 12'hB02, 32'd3);
    rd("minstreth", 12'hB82, 32'd0);
    rd_addr = 12'hB00;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst mcycle", rd_data, 32'h0);
    rd("async rst minstret", 12'hB02, 32'h0);
    chk("async rst mtvec_o", mtvec_o, 32'h8000_0100);
    chk("async rst mie_o", 32'(mie_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd("first count after reset", 12'hB00, 32'd1);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
